myproject_mul_share_sched: RTL and testbench

//  Time-multiplexes one signed x unsigned multiplier (16s x 10u -> 26b) among NUM_REQ requesters.

---
 rtl/myproject_mul_share_sched.sv | 118 +++++++++++
 tb/tb_myproject_mul_share_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_share_sched.sv
// Shares one signed x unsigned multiplier among NUM_REQ requesters through a round-robin
// arbiter, a 2-stage pipeline and a single tagged response bus with backpressure.
module myproject_mul_share_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned A_WIDTH  = 16,
  parameter int unsigned B_WIDTH  = 10,
  parameter int unsigned P_WIDTH  = 26,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_product,
  output logic                         busy
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                s1_valid_q;
  logic [ID_WIDTH-1:0] s1_id_q;
  logic [A_WIDTH-1:0]  s1_a_q;
  logic [B_WIDTH-1:0]  s1_b_q;
  logic                rsp_valid_q;
  logic [ID_WIDTH-1:0] rsp_id_q;
  logic [P_WIDTH-1:0]  rsp_product_q;

  logic                adv;
  logic                gnt_found;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic [ID_WIDTH-1:0] cand;
  logic                xfer;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;

  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] b_ext;
  logic signed [P_WIDTH-1:0] prod;

  assign adv = !rsp_valid_q || rsp_ready;

  // Scan from the pointer upward, wrapping; only valid requesters can win.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign xfer = adv && gnt_found;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign a_sel = req_a[gnt_idx*A_WIDTH +: A_WIDTH];
  assign b_sel = req_b[gnt_idx*B_WIDTH +: B_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Operands are widened to the product width so the truncated product is exact.
  assign a_ext = {{(P_WIDTH-A_WIDTH){s1_a_q[A_WIDTH-1]}}, s1_a_q};
  assign b_ext = {{(P_WIDTH-B_WIDTH){1'b0}}, s1_b_q};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (adv) begin
        s1_valid_q  <= xfer;
        rsp_valid_q <= s1_valid_q;
        // Data registers load only with valid entries so idle lanes never leak X.
        if (xfer) begin
          s1_id_q <= gnt_idx;
          s1_a_q  <= a_sel;
          s1_b_q  <= b_sel;
        end
        if (s1_valid_q) begin
          rsp_id_q      <= s1_id_q;
          rsp_product_q <= prod;
        end
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
// Directed bench for myproject_mul_share_sched: table of single products plus hand-written
// sequences for round-robin order, wrap, backpressure and mid-flight reset.
module tb_myproject_mul_share_sched;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [39:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [25:0] rsp_product;
  logic        busy;

  int n_vec;
  int n_err;

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  vec_t vecs[6];
  int   sa[4];
  int   sb[4];

  myproject_mul_share_sched dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] p26(input int p);
    return 32'(p) & 32'h03FF_FFFF;
  endfunction

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
  endtask

  task automatic load_lanes();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(sa[i]);
      req_b[i*10 +: 10] = 10'(sb[i]);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (3) @(negedge ap_clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{0, -32768, 1023, -33521664};
    vecs[1] = '{1,  32767, 1023,  33520641};
    vecs[2] = '{2,     -1,    0,         0};
    vecs[3] = '{3,     -5,    3,       -15};
    vecs[4] = '{0,    100,    7,       700};
    vecs[5] = '{2,   -300,  512,   -153600};
    for (int i = 0; i < 4; i++) begin
      sa[i] = -(i + 1) * 1000;
      sb[i] = (i + 3) * 10;
    end

    // Reset state
    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_product", {6'd0, rsp_product}, 32'd0);

    // Single-product table; idle lanes carry X
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      req_a = 'x;
      req_b = 'x;
      req_a[vecs[i].id*16 +: 16] = 16'(vecs[i].a);
      req_b[vecs[i].id*10 +: 10] = 10'(vecs[i].b);
      req_valid = 4'b0001 << vecs[i].id;
      rsp_ready = 1'b1;
      #1;
      chk("vec_ready", 32'(req_ready), 32'(4'b0001 << vecs[i].id));
      @(negedge ap_clk);
      req_valid = '0;
      #1;
      chk("vec_s1_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("vec_s1_busy", 32'(busy), 32'd1);
      @(negedge ap_clk);
      #1;
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
      chk("vec_rsp_product", {6'd0, rsp_product}, p26(vecs[i].p));
      @(negedge ap_clk);
      #1;
      chk("vec_idle_valid", 32'(rsp_valid), 32'd0);
      chk("vec_idle_busy", 32'(busy), 32'd0);
    end

    // Full-rate round robin 0,1,2,3,0,...
    do_reset();
    @(negedge ap_clk);
    load_lanes();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge ap_clk);
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
        chk("rr_rsp_product", {6'd0, rsp_product},
            p26(sa[(k - 2) % 4] * sb[(k - 2) % 4]));
      end
    end
    drain();

    // Wrap: grant 2, then 0101 gives 0 then 2
    do_reset();
    @(negedge ap_clk);
    load_lanes();
    req_valid = 4'b0100;
    #1;
    chk("wrap_first", 32'(req_ready), 32'b0100);
    @(negedge ap_clk);
    req_valid = 4'b0101;
    #1;
    chk("wrap_to_0", 32'(req_ready), 32'b0001);
    @(negedge ap_clk);
    #1;
    chk("wrap_to_2", 32'(req_ready), 32'b0100);
    drain();

    // Backpressure with two entries in flight
    do_reset();
    @(negedge ap_clk);
    load_lanes();
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge ap_clk);
      #1;
    end
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready_gated", 32'(req_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge ap_clk);
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_product", {6'd0, rsp_product}, p26(sa[0] * sb[0]));
      chk("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_rel_id0", 32'(rsp_id), 32'd0);
    @(negedge ap_clk);
    #1;
    chk("bp_rel_valid1", 32'(rsp_valid), 32'd1);
    chk("bp_rel_id1", 32'(rsp_id), 32'd1);
    chk("bp_rel_product1", {6'd0, rsp_product}, p26(sa[1] * sb[1]));
    @(negedge ap_clk);
    #1;
    chk("bp_rel_empty", 32'(rsp_valid), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);

    // Reset with two entries in flight
    do_reset();
    @(negedge ap_clk);
    load_lanes();
    req_valid = 4'hF;
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_valid_before", 32'(rsp_valid), 32'd1);
    #2;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_valid_drop", 32'(rsp_valid), 32'd0);
    chk("mid_busy_drop", 32'(busy), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge ap_clk);
      #1;
      chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'hF;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'b0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
